// File: rtl/mem_access_ctrl.sv
// Load/store access controller between the pipeline's memory stage and a
// registered-read data memory. One access in flight; requests are checked
// for opcode, alignment and range before any strobe is raised.
module mem_access_ctrl #(
    parameter int WORD  = 64,
    parameter int DEPTH = 32
) (
    input  logic            im_clk,
    input  logic            im_rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_load,
    input  logic            req_store,
    input  logic [WORD-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [WORD-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_read,
    output logic            mem_write,
    output logic [WORD-1:0] mem_addr,
    output logic [WORD-1:0] mem_wdata,
    input  logic [WORD-1:0] mem_rdata,
    output logic [15:0]     load_cnt,
    output logic [15:0]     store_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic            load;
        logic [WORD-1:0] addr;
        logic [WORD-1:0] wdata;
    } req_t;

    state_t state, state_nxt;
    req_t   req_q;
    logic   live_q;
    logic   accept;
    logic   bad_req;

    assign bad_req = (req_load == req_store) ||
                     (req_addr[2:0] != 3'b000) ||
                     ((req_addr >> 3) >= WORD'(DEPTH));

    assign accept = req_valid && req_ready;

    always_ff @(posedge im_clk or negedge im_rst_n) begin
        if (!im_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Strobes and memory address/data are decoded from state so that an
    // asynchronous reset clears them immediately, mid-cycle.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                req_ready = live_q;
                if (req_valid && live_q) state_nxt = bad_req ? RESP : ISSUE;
            end
            ISSUE: begin
                mem_read  = req_q.load;
                mem_write = !req_q.load;
                mem_addr  = req_q.addr;
                mem_wdata = req_q.wdata;
                state_nxt = WAIT;
            end
            WAIT: begin
                mem_addr  = req_q.addr;
                mem_wdata = req_q.wdata;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // live_q keeps req_ready low until the first edge after reset release.
    always_ff @(posedge im_clk or negedge im_rst_n) begin
        if (!im_rst_n) begin
            live_q     <= 1'b0;
            req_q      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            load_cnt   <= '0;
            store_cnt  <= '0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                req_q      <= '{load: req_load, addr: req_addr, wdata: req_wdata};
                resp_err   <= bad_req;
                resp_rdata <= '0;
            end
            // The only edge at which the memory drives valid read data.
            if (state == WAIT && req_q.load) resp_rdata <= mem_rdata;
            if (state == RESP && resp_ready && !resp_err) begin
                if (req_q.load) begin
                    if (load_cnt != 16'hFFFF) load_cnt <= load_cnt + 16'd1;
                end else begin
                    if (store_cnt != 16'hFFFF) store_cnt <= store_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a registered-read word memory model.
module tb_mem_access_ctrl;

    logic        im_clk = 1'b0;
    logic        im_rst_n;
    logic        req_valid, req_ready, req_load, req_store;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] load_cnt, store_cnt;

    int tests = 0;
    int fails = 0;

    mem_access_ctrl #(.WORD(64), .DEPTH(32)) dut (
        .im_clk(im_clk), .im_rst_n(im_rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .load_cnt(load_cnt), .store_cnt(store_cnt)
    );

    always #5 im_clk = ~im_clk;

    // Memory model: write on strobe, read data valid only in the cycle after
    // a read strobe; otherwise a junk pattern stands in for the floating bus.
    logic [63:0] mem [32];
    logic [63:0] rdq;
    logic        rd_oe;
    always @(posedge im_clk) begin
        if (mem_write) mem[mem_addr[7:3]] <= mem_wdata;
        rd_oe <= mem_read;
        if (mem_read) rdq <= mem[mem_addr[7:3]];
    end
    assign mem_rdata = rd_oe ? rdq : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge im_clk);
        @(negedge im_clk);
    endtask

    task automatic drive(input logic ld, input logic st, input logic [63:0] a, input logic [63:0] d);
        req_valid = 1'b1; req_load = ld; req_store = st; req_addr = a; req_wdata = d;
    endtask

    task automatic idle_req();
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_addr = 64'hFFFF_FFFF_FFFF_FFF8; req_wdata = 64'h5555_5555_5555_5555;
    endtask

    // Complete load with resp_ready high; returns data and error seen in RESP.
    task automatic do_load(input logic [63:0] a, output logic [63:0] d, output logic e);
        drive(1'b1, 1'b0, a, 64'h0);
        step();
        idle_req();
        step();
        step();
        d = resp_rdata;
        e = resp_err;
        step();
    endtask

    logic [63:0] rd;
    logic        er;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 64'h0;
        im_rst_n = 1'b0; resp_ready = 1'b0; rd_oe = 1'b0; rdq = 64'h0;
        idle_req();
        repeat (2) @(negedge im_clk);

        chk1("rst_req_ready", req_ready, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_strobes", mem_read | mem_write, 1'b0);
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_rdata", resp_rdata, 64'h0);
        chk("rst_counts", {32'h0, load_cnt, store_cnt}, 64'h0);

        im_rst_n = 1'b1;
        #1 chk1("ready_before_edge", req_ready, 1'b0);
        step();
        chk1("ready_after_release", req_ready, 1'b1);

        // Store 0xDEADBEEF to 0x10
        resp_ready = 1'b1;
        drive(1'b0, 1'b1, 64'h10, 64'hDEADBEEF);
        step();
        idle_req();
        chk1("st_issue_write", mem_write, 1'b1);
        chk1("st_issue_read", mem_read, 1'b0);
        chk("st_issue_addr", mem_addr, 64'h10);
        chk("st_issue_wdata", mem_wdata, 64'hDEADBEEF);
        chk1("st_issue_ready", req_ready, 1'b0);
        step();
        chk1("st_wait_write", mem_write, 1'b0);
        chk("st_wait_addr", mem_addr, 64'h10);
        chk1("st_wait_valid", resp_valid, 1'b0);
        step();
        chk1("st_resp_valid", resp_valid, 1'b1);
        chk1("st_resp_err", resp_err, 1'b0);
        chk("st_resp_rdata", resp_rdata, 64'h0);
        step();
        chk1("st_done_valid", resp_valid, 1'b0);
        chk("st_done_addr", mem_addr, 64'h0);
        chk("st_store_cnt", {48'h0, store_cnt}, 64'h1);
        chk("st_mem_word", mem[2], 64'hDEADBEEF);

        // Load back from 0x10
        drive(1'b1, 1'b0, 64'h10, 64'h0);
        step();
        idle_req();
        chk1("ld_issue_read", mem_read, 1'b1);
        chk1("ld_issue_write", mem_write, 1'b0);
        step();
        chk1("ld_wait_valid", resp_valid, 1'b0);
        step();
        chk1("ld_resp_valid", resp_valid, 1'b1);
        chk("ld_rdata", resp_rdata, 64'hDEADBEEF);
        chk1("ld_err", resp_err, 1'b0);
        step();
        chk("ld_counts", {32'h0, load_cnt, store_cnt}, {32'h0, 16'h1, 16'h1});

        // Misaligned load
        drive(1'b1, 1'b0, 64'h13, 64'h0);
        step();
        idle_req();
        chk1("mis_valid", resp_valid, 1'b1);
        chk1("mis_err", resp_err, 1'b1);
        chk("mis_rdata", resp_rdata, 64'h0);
        chk1("mis_strobe", mem_read | mem_write, 1'b0);
        step();

        // Out-of-range store
        drive(1'b0, 1'b1, 64'h100, 64'h77);
        step();
        idle_req();
        chk1("oor_valid", resp_valid, 1'b1);
        chk1("oor_err", resp_err, 1'b1);
        chk1("oor_strobe", mem_read | mem_write, 1'b0);
        step();
        chk("err_counts", {32'h0, load_cnt, store_cnt}, {32'h0, 16'h1, 16'h1});
        chk("oor_mem_word0", mem[0], 64'h0);

        // Illegal opcodes: both set, neither set
        drive(1'b1, 1'b1, 64'h8, 64'h0);
        step();
        idle_req();
        chk1("both_err", resp_err, 1'b1);
        chk1("both_strobe", mem_read | mem_write, 1'b0);
        step();
        drive(1'b0, 1'b0, 64'h8, 64'h0);
        step();
        idle_req();
        chk1("none_err", resp_err, 1'b1);
        step();
        chk("illegal_counts", {32'h0, load_cnt, store_cnt}, {32'h0, 16'h1, 16'h1});

        // Backpressure on a load, with a store waiting behind it
        resp_ready = 1'b0;
        drive(1'b1, 1'b0, 64'h10, 64'h0);
        step();
        drive(1'b0, 1'b1, 64'h18, 64'h1234);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk1("bp_valid", resp_valid, 1'b1);
            chk("bp_rdata", resp_rdata, 64'hDEADBEEF);
            chk1("bp_err", resp_err, 1'b0);
            chk1("bp_ready", req_ready, 1'b0);
            step();
        end
        resp_ready = 1'b1;
        step();
        chk1("bp_exit_valid", resp_valid, 1'b0);
        chk1("bp_exit_ready", req_ready, 1'b1);
        chk1("bp_exit_nostrobe", mem_write, 1'b0);
        chk("bp_load_cnt", {48'h0, load_cnt}, 64'h2);
        step();
        idle_req();
        chk1("bp_next_write", mem_write, 1'b1);
        chk("bp_next_addr", mem_addr, 64'h18);
        step(); step(); step();
        chk("bp_store_cnt", {48'h0, store_cnt}, 64'h2);
        chk("bp_mem_word3", mem[3], 64'h1234);

        // Reset during ISSUE of a store
        drive(1'b0, 1'b1, 64'h10, 64'hCAFE);
        step();
        idle_req();
        chk1("rm_issue_write", mem_write, 1'b1);
        #2 im_rst_n = 1'b0;
        #1;
        chk1("rm_write_dropped", mem_write, 1'b0);
        chk("rm_addr_cleared", mem_addr, 64'h0);
        step();
        im_rst_n = 1'b1;
        step();
        chk("rm_mem_word", mem[2], 64'hDEADBEEF);
        chk("rm_counts", {32'h0, load_cnt, store_cnt}, 64'h0);
        chk1("rm_ready", req_ready, 1'b1);
        chk1("rm_no_resp", resp_valid, 1'b0);

        // Load counter saturation
        force dut.load_cnt = 16'hFFFE;
        #1 release dut.load_cnt;
        @(negedge im_clk);
        do_load(64'h18, rd, er);
        chk("sat_rdata", rd, 64'h1234);
        chk("sat_first", {48'h0, load_cnt}, 64'hFFFF);
        do_load(64'h10, rd, er);
        chk1("sat_err", er, 1'b0);
        do_load(64'h0, rd, er);
        chk("sat_final", {48'h0, load_cnt}, 64'hFFFF);
        chk("sat_store_cnt", {48'h0, store_cnt}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
